// File: rtl/dumbrv_lsu.sv
// dumbrv_lsu: load/store unit between execute and writeback.
// Memory ops are broken into little-endian byte beats on a simple
// req/ack byte bus; loads are reassembled and sign/zero-extended,
// non-memory ops pass straight through to writeback.
module dumbrv_lsu #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // execute-stage input
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [5:0]        op_i,
    input  logic [31:0]       val1_i,
    input  logic [31:0]       val2_i,
    input  logic [4:0]        rd_i,
    // byte memory bus
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_rdata_i,
    // writeback
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [31:0]       wb_data_o,
    output logic [4:0]        wb_rd_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_reg;
    state_e state_next;

    // Registered op context, captured on accept
    logic [ADDR_W-1:0] base_reg;
    logic [1:0]        beat_reg;
    logic [1:0]        last_beat_reg;
    logic              store_reg;
    logic              sign_reg;
    logic [31:0]       store_data_reg;
    logic [31:0]       load_buf_reg;
    logic [31:0]       wb_data_reg;
    logic [4:0]        rd_reg;

    // Decode of the incoming op
    logic       accept;
    logic       op_is_mem;
    logic [1:0] op_last_beat;

    // Beat bookkeeping
    logic       final_beat;
    logic       beat_done;

    // Load assembly
    logic [31:0] load_word;
    logic [31:0] load_result;

    // Store byte lanes
    logic [7:0] store_lane [4];

    // Top two op bits select memory ops; size_b wins over size_h
    assign op_is_mem    = (op_i[5:4] == 2'b10);
    assign op_last_beat = op_i[0] ? 2'd0 : (op_i[1] ? 2'd1 : 2'd3);

    // in_ready_o is purely state-decoded, so accept needs only the state
    assign accept     = in_valid_i && (state_reg == IDLE);
    assign final_beat = (beat_reg == last_beat_reg);
    // Acks outside ACCESS fall through this gate and are ignored
    assign beat_done  = (state_reg == ACCESS) && mem_ack_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (in_valid_i) begin
                    state_next = op_is_mem ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (mem_ack_i && final_beat) begin
                    state_next = store_reg ? IDLE : RESP;
                end
            end
            RESP: begin
                // Return to IDLE only; a new op waits for the next cycle
                if (wb_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        in_ready_o = (state_reg == IDLE);
        mem_req_o  = (state_reg == ACCESS);
        wb_valid_o = (state_reg == RESP);
    end

    // Split store data into byte lanes so the beat index picks one directly
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
            assign store_lane[gi] = store_data_reg[8*gi +: 8];
        end
    endgenerate

    // Bus address wraps naturally at 2^ADDR_W; no alignment check
    assign mem_addr_o  = base_reg + {{(ADDR_W-2){1'b0}}, beat_reg};
    assign mem_we_o    = store_reg;
    assign mem_wdata_o = store_lane[beat_reg];

    assign wb_data_o = wb_data_reg;
    assign wb_rd_o   = rd_reg;

    // Merge the byte arriving this beat into the collected bytes and extend
    always_comb begin
        load_word = load_buf_reg;
        load_word[{beat_reg, 3'b000} +: 8] = mem_rdata_i;
        load_result = load_word;
        case (last_beat_reg)
            2'd0: load_result = sign_reg ? {{24{load_word[7]}}, load_word[7:0]}
                                         : {24'h000000, load_word[7:0]};
            2'd1: load_result = sign_reg ? {{16{load_word[15]}}, load_word[15:0]}
                                         : {16'h0000, load_word[15:0]};
            // Word loads ignore the sign bit
            default: load_result = load_word;
        endcase
    end

    // Op context capture, beat stepping and writeback data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_reg       <= '0;
            beat_reg       <= 2'd0;
            last_beat_reg  <= 2'd0;
            store_reg      <= 1'b0;
            sign_reg       <= 1'b0;
            store_data_reg <= 32'h0;
            load_buf_reg   <= 32'h0;
            wb_data_reg    <= 32'h0;
            rd_reg         <= 5'd0;
        end else if (accept) begin
            rd_reg <= rd_i;
            if (op_is_mem) begin
                base_reg       <= val1_i[ADDR_W-1:0];
                beat_reg       <= 2'd0;
                last_beat_reg  <= op_last_beat;
                store_reg      <= op_i[3];
                sign_reg       <= op_i[2];
                store_data_reg <= val2_i;
                load_buf_reg   <= 32'h0;
            end else begin
                wb_data_reg <= val1_i;
            end
        end else if (beat_done) begin
            if (!final_beat) begin
                beat_reg     <= beat_reg + 2'd1;
                load_buf_reg <= load_word;
            end else if (!store_reg) begin
                wb_data_reg <= load_result;
            end
        end
    end

endmodule
